multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I single-memory-port core.
- Walks every instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the immediate generator's select code, the PC/IR/regfile write strobes, datapath muxes and the shared memory request/ready handshake.
- Sits between the instruction register (instr input) and all datapath enables; holds no datapath values itself.

---
 rtl/riscv_ctrl_pkg.sv | 61 ++++++
 rtl/multicycle_ctrl_decode.sv | 101 ++++++++++
 rtl/multicycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared constants for the RV32I multi-cycle controller: major opcodes,
// immediate-generator format codes, PC/write-back mux codes, FSM state
// encoding and the instruction classes produced by the decoder.
// -----------------------------------------------------------------------------
package riscv_ctrl_pkg;

   // RV32I major opcodes (instr[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // Immediate-generator format codes; code 1 is reserved and never issued
   localparam logic [2:0] IMM_I    = 3'd0;
   localparam logic [2:0] IMM_ISH  = 3'd2;
   localparam logic [2:0] IMM_S    = 3'd3;
   localparam logic [2:0] IMM_B    = 3'd4;
   localparam logic [2:0] IMM_U    = 3'd5;
   localparam logic [2:0] IMM_J    = 3'd6;
   localparam logic [2:0] IMM_PASS = 3'd7;

   // Next-PC mux codes
   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_ALU    = 2'd1;
   localparam logic [1:0] PC_BRANCH = 2'd2;

   // Register write-back mux codes
   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MEM  = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;
   localparam logic [1:0] WB_IMM  = 2'd3;

   // Sequencer states; encoding is visible on state_o
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5,
      ST_BOOT   = 3'd7
   } state_e;

   // Instruction classes that steer the EXEC/MEM/WB path
   typedef enum logic [2:0] {
      CLS_ALU     = 3'd0,
      CLS_LOAD    = 3'd1,
      CLS_STORE   = 3'd2,
      CLS_BRANCH  = 3'd3,
      CLS_JUMP    = 3'd4,
      CLS_ILLEGAL = 3'd5
   } instr_class_e;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_decode
// Purely combinational opcode decoder for the multi-cycle controller.
// Ports:
//   opcode    in  7  instr[6:0]
//   funct3    in  3  instr[14:12] (selects shift-immediate format)
//   cls       out    instruction class
//   imm_sel   out 3  immediate-generator format code
//   wb_sel    out 2  write-back source
//   alu_a_sel out 1  0 = rs1, 1 = PC
//   alu_b_sel out 1  0 = rs2, 1 = immediate
//   illegal   out 1  opcode is not an RV32I opcode handled by the core
// -----------------------------------------------------------------------------
module multicycle_ctrl_decode
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0]   opcode,
   input  logic [2:0]   funct3,
   output instr_class_e cls,
   output logic [2:0]   imm_sel,
   output logic [1:0]   wb_sel,
   output logic         alu_a_sel,
   output logic         alu_b_sel,
   output logic         illegal
);

   // Opcode to class and datapath-select table
   always_comb begin
      cls       = CLS_ILLEGAL;
      imm_sel   = IMM_PASS;
      wb_sel    = WB_ALU;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b1;
      illegal   = 1'b1;
      case (opcode)
         OPC_OP_IMM: begin
            cls     = CLS_ALU;
            illegal = 1'b0;
            // SLLI/SRLI/SRAI carry a 5-bit shamt rather than a 12-bit imm
            if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
               imm_sel = IMM_ISH;
            end else begin
               imm_sel = IMM_I;
            end
         end
         OPC_OP: begin
            cls       = CLS_ALU;
            illegal   = 1'b0;
            imm_sel   = IMM_PASS;
            alu_b_sel = 1'b0;
         end
         OPC_LOAD: begin
            cls     = CLS_LOAD;
            illegal = 1'b0;
            imm_sel = IMM_I;
            wb_sel  = WB_MEM;
         end
         OPC_STORE: begin
            cls     = CLS_STORE;
            illegal = 1'b0;
            imm_sel = IMM_S;
         end
         OPC_BRANCH: begin
            cls       = CLS_BRANCH;
            illegal   = 1'b0;
            imm_sel   = IMM_B;
            alu_a_sel = 1'b1;
         end
         OPC_JAL: begin
            cls       = CLS_JUMP;
            illegal   = 1'b0;
            imm_sel   = IMM_J;
            wb_sel    = WB_PC4;
            alu_a_sel = 1'b1;
         end
         OPC_JALR: begin
            cls     = CLS_JUMP;
            illegal = 1'b0;
            imm_sel = IMM_I;
            wb_sel  = WB_PC4;
         end
         OPC_LUI: begin
            cls     = CLS_ALU;
            illegal = 1'b0;
            imm_sel = IMM_U;
            wb_sel  = WB_IMM;
         end
         OPC_AUIPC: begin
            cls       = CLS_ALU;
            illegal   = 1'b0;
            imm_sel   = IMM_U;
            alu_a_sel = 1'b1;
         end
         default: begin
            cls     = CLS_ILLEGAL;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// FETCH/DECODE/EXEC/MEM/WB sequencer for the single-memory-port RV32I core.
// All outputs are decoded combinationally from the state register, the IR
// contents and mem_ready; the block holds no datapath values.
// Build option: define ILLEGAL_TRAP_EN to lock up in TRAP on an illegal
// opcode (exit only via rst_n); otherwise illegal opcodes retire as NOPs.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr[31:0]           IR contents, valid from DECODE onward
//   mem_ready, br_taken   memory completion, branch comparator result
//   mem_req/mem_we/mem_addr_sel   shared memory request
//   ir_we, pc_we, pc_sel[1:0], reg_we, wb_sel[1:0]   datapath strobes/muxes
//   imm_sel[2:0], alu_a_sel, alu_b_sel                operand selects
//   state_o[2:0], mem_err, illegal                    status
// Parameters: MEM_WAIT_MAX (0 disables the timeout), CNT_W with
//   2**CNT_W > MEM_WAIT_MAX.
// -----------------------------------------------------------------------------
module multicycle_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        br_taken,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic [2:0]  imm_sel,
   output logic        alu_a_sel,
   output logic        alu_b_sel,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic [2:0]  state_o,
   output logic        mem_err,
   output logic        illegal
);

   localparam logic             TMO_EN   = (MEM_WAIT_MAX != 0);
   localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MEM_WAIT_MAX);

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   instr_class_e     dec_cls_s;
   logic [2:0]       dec_imm_sel_s;
   logic [1:0]       dec_wb_sel_s;
   logic             dec_a_sel_s;
   logic             dec_b_sel_s;
   logic             dec_illegal_s;
   logic             wait_expired_s;
   logic [CNT_W-1:0] cnt_wait_s;
   logic             unused_instr_s;

   // Upper IR fields are consumed by the immediate generator, not here
   assign unused_instr_s = ^{instr[31:15]};

   multicycle_ctrl_decode u_decode (
      .opcode    (instr[6:0]),
      .funct3    (instr[14:12]),
      .cls       (dec_cls_s),
      .imm_sel   (dec_imm_sel_s),
      .wb_sel    (dec_wb_sel_s),
      .alu_a_sel (dec_a_sel_s),
      .alu_b_sel (dec_b_sel_s),
      .illegal   (dec_illegal_s)
   );

   // Timeout fires when the wait count has reached the limit; the counter
   // then restarts so the request is retried with a fresh budget.
   assign wait_expired_s = TMO_EN && (cnt_q == WAIT_LIM);
   assign cnt_wait_s     = (wait_expired_s || !TMO_EN) ? CNT_W'(0) : (cnt_q + CNT_W'(1));

   // State and wait-counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
         cnt_q   <= CNT_W'(0);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and Moore/handshake output decode
   always_comb begin
      state_d      = state_q;
      cnt_d        = CNT_W'(0);
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = PC_PLUS4;
      imm_sel      = dec_imm_sel_s;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = WB_ALU;
      mem_err      = 1'b0;
      illegal      = 1'b0;
      case (state_q)
         ST_BOOT: begin
            imm_sel = IMM_PASS;
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            imm_sel = IMM_PASS;
            mem_req = 1'b1;
            // ready wins over a timeout landing in the same cycle
            if (mem_ready) begin
               ir_we   = 1'b1;
               state_d = ST_DECODE;
            end else begin
               mem_err = wait_expired_s;
               cnt_d   = cnt_wait_s;
            end
         end
         ST_DECODE: begin
            if (dec_illegal_s) begin
`ifdef ILLEGAL_TRAP_EN
               state_d = ST_TRAP;
`else
               state_d = ST_WB;
`endif
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_a_sel = dec_a_sel_s;
            alu_b_sel = dec_b_sel_s;
            case (dec_cls_s)
               CLS_LOAD, CLS_STORE: begin
                  state_d = ST_MEM;
               end
               CLS_BRANCH: begin
                  pc_we   = 1'b1;
                  pc_sel  = br_taken ? PC_BRANCH : PC_PLUS4;
                  state_d = ST_FETCH;
               end
               default: begin
                  state_d = ST_WB;
               end
            endcase
         end
         ST_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (dec_cls_s == CLS_STORE);
            if (mem_ready) begin
               if (dec_cls_s == CLS_STORE) begin
                  pc_we   = 1'b1;
                  pc_sel  = PC_PLUS4;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end else begin
               mem_err = wait_expired_s;
               cnt_d   = cnt_wait_s;
            end
         end
         ST_WB: begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
            // illegal opcodes arriving here retire as a NOP: PC+4 only
            if (dec_illegal_s) begin
               reg_we = 1'b0;
               pc_sel = PC_PLUS4;
               wb_sel = WB_ALU;
            end else begin
               reg_we = (instr[11:7] != 5'd0);
               wb_sel = dec_wb_sel_s;
               pc_sel = (dec_cls_s == CLS_JUMP) ? PC_ALU : PC_PLUS4;
            end
         end
         ST_TRAP: begin
            imm_sel = IMM_PASS;
            state_d = ST_TRAP;
`ifdef ILLEGAL_TRAP_EN
            illegal = 1'b1;
`else
            illegal = 1'b0;
`endif
         end
         default: begin
            imm_sel = IMM_PASS;
            state_d = ST_BOOT;
         end
      endcase
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed and randomized instruction stream for multicycle_ctrl. The
// reference model expands each instruction into its expected phase list
// (FETCH waits, DECODE, EXEC, MEM waits, WB) and the outputs each phase
// must show, derived from the instruction kind.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam int WAIT_MAX = 15;

   localparam int K_OP = 0, K_OPIMM = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4,
                  K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9;

   typedef struct packed {
      logic [2:0] st;
      logic       req;
      logic       we;
      logic       asel;
      logic       irwe;
      logic       pcwe;
      logic [1:0] pcs;
      logic [2:0] imm;
      logic       a;
      logic       b;
      logic       rwe;
      logic [1:0] wbs;
      logic       err;
      logic       ill;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'd0;
   logic        mem_ready = 1'b0;
   logic        br_taken = 1'b0;
   logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_a_sel, alu_b_sel;
   logic        reg_we, mem_err, illegal;
   logic [1:0]  pc_sel, wb_sel;
   logic [2:0]  imm_sel, state_o;

   int checks = 0;
   int errors = 0;

   obs_t got;

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
      .br_taken(br_taken), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
      .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_a_sel(alu_a_sel),
      .alu_b_sel(alu_b_sel), .reg_we(reg_we), .wb_sel(wb_sel),
      .state_o(state_o), .mem_err(mem_err), .illegal(illegal)
   );

   always #5 clk = ~clk;

   assign got = {state_o, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                 imm_sel, alu_a_sel, alu_b_sel, reg_we, wb_sel, mem_err, illegal};

   function automatic int kind_of(input logic [31:0] i);
      case (i[6:0])
         7'b0110011: return K_OP;
         7'b0010011: return K_OPIMM;
         7'b0000011: return K_LOAD;
         7'b0100011: return K_STORE;
         7'b1100011: return K_BR;
         7'b1101111: return K_JAL;
         7'b1100111: return K_JALR;
         7'b0110111: return K_LUI;
         7'b0010111: return K_AUIPC;
         default:    return K_ILL;
      endcase
   endfunction

   function automatic logic [2:0] imm_of(input logic [31:0] i);
      case (kind_of(i))
         K_OPIMM:        return ((i[14:12] == 3'b001) || (i[14:12] == 3'b101)) ? 3'd2 : 3'd0;
         K_LOAD, K_JALR: return 3'd0;
         K_STORE:        return 3'd3;
         K_BR:           return 3'd4;
         K_LUI, K_AUIPC: return 3'd5;
         K_JAL:          return 3'd6;
         default:        return 3'd7;
      endcase
   endfunction

   function automatic logic [1:0] wbs_of(input int k);
      if (k == K_LOAD) return 2'd1;
      if (k == K_JAL || k == K_JALR) return 2'd2;
      if (k == K_LUI) return 2'd3;
      return 2'd0;
   endfunction

   // expected timeout pulse on wait cycle idx of a phase that is ready at cycle d
   function automatic logic err_at(input int idx, input int d);
      return (idx < d) && (((idx + 1) % (WAIT_MAX + 1)) == 0);
   endfunction

   function automatic obs_t boot_e();
      obs_t e = '0;
      e.st = 3'd7;
      e.imm = 3'd7;
      return e;
   endfunction

   task automatic check(input string tag, input obs_t e, input bit imm_care);
      obs_t m;
      m = '1;
      if (!imm_care) m.imm = 3'b000;
      checks++;
      assert ((got & m) === (e & m)) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (st %0d/%0d)", tag, got & m, e & m, got.st, e.st);
      end
   endtask

   task automatic step(input string tag, input obs_t e, input bit imm_care);
      @(negedge clk);
      check(tag, e, imm_care);
      @(posedge clk);
      #1;
   endtask

   // asynchronous reset from any point in the cycle, then release into BOOT
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_async", boot_e(), 1'b1);
      @(posedge clk);
      #1;
      check("rst_hold", boot_e(), 1'b1);
      rst_n = 1'b1;
      mem_ready = 1'b0;
      step("boot", boot_e(), 1'b1);
   endtask

   // one instruction from FETCH to retirement; abort_mem>=0 resets in that MEM cycle
   task automatic run_instr(input logic [31:0] ins, input int df, input int dm,
                            input bit br, input int abort_mem);
      int   k;
      obs_t e;
      k = kind_of(ins);
      instr = ins;
      br_taken = br;
      for (int c = 0; c <= df; c++) begin
         mem_ready = (c == df);
         e = '0; e.st = 3'd0; e.req = 1'b1; e.imm = 3'd7;
         e.irwe = (c == df); e.err = err_at(c, df);
         step("fetch", e, 1'b1);
      end
      mem_ready = 1'($urandom_range(0, 1));
      e = '0; e.st = 3'd1; e.imm = imm_of(ins);
      step("decode", e, k != K_ILL);
      if (k == K_ILL) begin
`ifdef ILLEGAL_TRAP_EN
         for (int c = 0; c < 4; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            e = '0; e.st = 3'd5; e.ill = 1'b1;
            step("trap_hold", e, 1'b0);
         end
         do_reset();
`else
         mem_ready = 1'($urandom_range(0, 1));
         e = '0; e.st = 3'd4; e.pcwe = 1'b1;
         step("nop_wb", e, 1'b0);
`endif
         return;
      end
      mem_ready = 1'($urandom_range(0, 1));
      e = '0; e.st = 3'd2; e.imm = imm_of(ins);
      e.a = (k == K_AUIPC || k == K_JAL || k == K_BR);
      e.b = (k != K_OP);
      if (k == K_BR) begin
         e.pcwe = 1'b1;
         e.pcs = br ? 2'd2 : 2'd0;
      end
      step("exec", e, 1'b1);
      if (k == K_BR) return;
      if (k == K_LOAD || k == K_STORE) begin
         for (int c = 0; c <= dm; c++) begin
            if (c == abort_mem) begin
               mem_ready = 1'b0;
               #2;
               do_reset();
               return;
            end
            mem_ready = (c == dm);
            e = '0; e.st = 3'd3; e.req = 1'b1; e.asel = 1'b1; e.imm = imm_of(ins);
            e.we = (k == K_STORE); e.err = err_at(c, dm);
            if (k == K_STORE && c == dm) e.pcwe = 1'b1;
            step("mem", e, 1'b1);
         end
         if (k == K_STORE) return;
      end
      mem_ready = 1'($urandom_range(0, 1));
      e = '0; e.st = 3'd4; e.imm = imm_of(ins); e.pcwe = 1'b1;
      e.rwe = (ins[11:7] != 5'd0);
      e.pcs = (k == K_JAL || k == K_JALR) ? 2'd1 : 2'd0;
      e.wbs = wbs_of(k);
      step("wb", e, 1'b1);
   endtask

   function automatic logic [31:0] rand_instr(input int k);
      logic [31:0] r;
      logic [6:0]  ill_tab [4];
      ill_tab = '{7'h7F, 7'h0F, 7'h73, 7'h00};
      r = $urandom;
      case (k)
         K_OP:    r[6:0] = 7'b0110011;
         K_OPIMM: r[6:0] = 7'b0010011;
         K_LOAD:  r[6:0] = 7'b0000011;
         K_STORE: r[6:0] = 7'b0100011;
         K_BR:    r[6:0] = 7'b1100011;
         K_JAL:   r[6:0] = 7'b1101111;
         K_JALR:  r[6:0] = 7'b1100111;
         K_LUI:   r[6:0] = 7'b0110111;
         K_AUIPC: r[6:0] = 7'b0010111;
         default: r[6:0] = ill_tab[$urandom_range(0, 3)];
      endcase
      if ($urandom_range(0, 3) == 0) r[11:7] = 5'd0;
      return r;
   endfunction

   initial begin
      #12;
      check("reset_state", boot_e(), 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("boot_release", boot_e(), 1'b1);

      // ADDI x1: 7,0,1,2,4,0
      run_instr(32'h00500093, 0, 0, 1'b0, -1);
      // LW with three MEM wait cycles
      run_instr(32'h0000A103, 0, 3, 1'b0, -1);
      // BEQ taken / not taken
      run_instr(32'h00208463, 0, 0, 1'b1, -1);
      run_instr(32'h00208463, 0, 0, 1'b0, -1);
      // fetch timeout: pulses on wait cycles 16 and 32, then ready
      run_instr(32'h00500093, 40, 0, 1'b0, -1);
      // ready on the same cycle the count reaches the limit: no pulse
      run_instr(32'h00500093, 15, 0, 1'b0, -1);
      // store MEM timeout and retry
      run_instr(32'h0020A023, 2, 17, 1'b0, -1);
      // illegal opcode
      run_instr(32'h0000007F, 0, 0, 1'b0, -1);
      // reset during SW in MEM
      run_instr(32'h0020A023, 1, 5, 1'b0, 2);

      for (int n = 0; n < 80; n++) begin
         logic [31:0] ri;
         ri = rand_instr($urandom_range(0, 9));
         run_instr(ri, $urandom_range(0, 20), $urandom_range(0, 20),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0) ? 0 : -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
